// File: rtl/mix_state_seq.sv
// Iterative AES MixColumns / InvMixColumns over a full 128-bit state,
// transforming COLS_PER_CYCLE columns per clock behind valid/ready handshakes.
module mix_state_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_state_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // col index arithmetic is mod 4, so a step of 4 truncates to 0 and LAST to 0
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   col_q, col_d;
    logic         mode_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k is a 4-bit coefficient; every MixColumns constant fits in 0x0..0xf
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [3:0]  k [4];
        logic [7:0]  acc;
        logic [31:0] res;
        if (inv) begin
            k[0] = 4'he; k[1] = 4'hb; k[2] = 4'hd; k[3] = 4'h9;
        end else begin
            k[0] = 4'h2; k[1] = 4'h3; k[2] = 4'h1; k[3] = 4'h1;
        end
        res = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            acc = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                acc = acc ^ gmul(col[31 - 8*j -: 8], k[(j + 4 - r) % 4]);
            end
            res[31 - 8*r -: 8] = acc;
        end
        return res;
    endfunction

    always_comb begin
        int unsigned c;
        state_d = state_q;
        work_d  = work_q;
        col_d   = col_q;
        c       = 0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    work_d  = state_in;
                    col_d   = '0;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
                    c = (int'(col_q) + i) % 4;
                    work_d[127 - 32*c -: 32] = mix_col(work_q[127 - 32*c -: 32], mode_q);
                end
                col_d = col_q + STEP;
                if (col_q == LAST) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            col_q     <= '0;
            mode_q    <= 1'b0;
            state_out <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            col_q   <= col_d;
            if (state_q == IDLE && in_valid) mode_q <= inverse;
            // separate output register so the next accept cannot disturb state_out
            if (state_q == RUN && col_q == LAST) state_out <= work_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mix_state_seq.sv
// Directed bench for mix_state_seq: three instances (1, 2, 4 columns per cycle)
// checked against hand-computed AES MixColumns vectors.
module tb_mix_state_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         inverse   [3];
    logic [127:0] state_in  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];
    logic         busy      [3];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_state_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .inverse   (inverse[g]),
            .state_in  (state_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    localparam logic [127:0] R1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    // accept one state on unit u, measure latency, check result, then drain it
    task automatic run_vec(input int u, input logic [127:0] st, input logic inv,
                           input logic [127:0] exp, input int lat, input string tag);
        int cycles;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 128'(in_ready[u]), 128'd1);
        in_valid[u]  = 1'b1;
        state_in[u]  = st;
        inverse[u]   = inv;
        out_ready[u] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        state_in[u] = ~st;
        inverse[u]  = ~inv;
        cycles = 0;
        while (!out_valid[u] && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq({tag, " latency"}, 128'(cycles), 128'(lat));
        check_eq({tag, " result"}, state_out[u], exp);
        check_eq({tag, " busy"}, 128'(busy[u]), 128'd1);
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        check_eq({tag, " drained"}, 128'({out_valid[u], in_ready[u]}), 128'b01);
        check_eq({tag, " held"}, state_out[u], exp);
    endtask

    initial begin
        int cycles;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            inverse[i]   = 1'b0;
            state_in[i]  = '0;
            out_ready[i] = 1'b0;
        end
        #22;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset u%0d flags", i),
                     128'({in_ready[i], out_valid[i], busy[i]}), 128'b100);
            check_eq($sformatf("reset u%0d state_out", i), state_out[i], '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(0, {4{32'hf5afc959}}, 1'b0, {4{32'h8ba938d0}}, 4, "col f5afc959 n1");
        run_vec(0, R1_IN, 1'b0, R1_OUT, 4, "fips r1 n1");
        run_vec(1, R1_IN, 1'b0, R1_OUT, 2, "fips r1 n2");
        run_vec(2, R1_IN, 1'b0, R1_OUT, 1, "fips r1 n4");
        run_vec(0, R1_OUT, 1'b1, R1_IN, 4, "inv r1 n1");
        run_vec(2, R1_OUT, 1'b1, R1_IN, 1, "inv r1 n4");
        run_vec(1, {4{32'hfbaa43f2}}, 1'b0, {4{32'hb983da00}}, 2, "fwd fbaa43f2");
        run_vec(1, {4{32'hb983da00}}, 1'b1, {4{32'hfbaa43f2}}, 2, "inv b983da00");
        run_vec(0, {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c}, 1'b0,
                {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8}, 4, "mixed cols");

        // backpressure: result must hold while a second state is offered
        @(negedge clk);
        in_valid[0] = 1'b1;
        state_in[0] = R1_IN;
        inverse[0]  = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        cycles = 0;
        while (!out_valid[0] && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("bp latency", 128'(cycles), 128'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0] = 1'b1;
            state_in[0] = {4{32'hc6c6c6c6}};
            inverse[0]  = 1'b1;
            @(posedge clk);
            #1;
            check_eq($sformatf("bp stall %0d flags", i),
                     128'({out_valid[0], in_ready[0], busy[0]}), 128'b101);
            check_eq($sformatf("bp stall %0d state", i), state_out[0], R1_OUT);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp release flags", 128'({out_valid[0], in_ready[0], busy[0]}), 128'b010);
        @(negedge clk);
        out_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        check_eq("bp not captured", 128'({busy[0], in_ready[0]}), 128'b01);
        check_eq("bp state kept", state_out[0], R1_OUT);

        // reset two cycles into a 4-cycle run
        @(negedge clk);
        in_valid[0] = 1'b1;
        state_in[0] = R1_IN;
        inverse[0]  = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("mid-run busy", 128'({busy[0], out_valid[0]}), 128'b10);
        rst_n = 1'b0;
        #1;
        check_eq("reset mid-run flags", 128'({busy[0], out_valid[0], in_ready[0]}), 128'b001);
        check_eq("reset mid-run state", state_out[0], '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(0, {4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}, 4, "post-rst c6 fwd");
        run_vec(0, {4{32'hc6c6c6c6}}, 1'b1, {4{32'hc6c6c6c6}}, 4, "post-rst c6 inv");
        run_vec(0, {4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 4, "post-rst 01 fwd");
        run_vec(0, {4{32'h01010101}}, 1'b1, {4{32'h01010101}}, 4, "post-rst 01 inv");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
